// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control FSM (IF/ID/EXE/MEM/WB) for a single-issue MIPS-like datapath.
// Optional retired-instruction counter is built only when CU_INSTR_COUNT_EN is defined.
module multicycle_control_unit #(
   parameter logic [5:0] HALT_OPCODE = 6'b111111,
   parameter int         CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [5:0]       Opcode,
   input  logic             Zero,
   output logic             IRWre,
   output logic             PCWre,
   output logic [1:0]       PCSrc,
   output logic             ExtSel,
   output logic             ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic             mRD,
   output logic             mWR,
   output logic             RegDst,
   output logic             RegWre,
   output logic             DBDataSrc,
   output logic [2:0]       State,
   output logic             Halted,
   output logic [CNT_W-1:0] InstrCount
);
   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_ANDI  = 6'b010000;
   localparam logic [5:0] OP_AND   = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_OR    = 6'b010011;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_J     = 6'b111000;

   // Low three bits are the visible state code; HALT sits outside that code space.
   typedef enum logic [3:0] {
      S_IF     = 4'b0000,
      S_ID     = 4'b0001,
      S_EXE_LS = 4'b0010,
      S_MEM    = 4'b0011,
      S_WB_LD  = 4'b0100,
      S_EXE_BR = 4'b0101,
      S_EXE_AL = 4'b0110,
      S_WB_AL  = 4'b0111,
      S_HALT   = 4'b1000
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic [5:0] op;
   logic       is_rtype, is_imm, is_mem, is_br;

   // Opcode is sampled live only in ID and held afterwards, so later input noise is ignored.
   assign op   = (state_q == S_ID) ? Opcode : op_q;
   assign op_d = (state_q == S_ID) ? Opcode : op_q;

   assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                     (op == OP_OR)  || (op == OP_SLT);
   assign is_imm   = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI);
   assign is_mem   = (op == OP_LW) || (op == OP_SW);
   assign is_br    = (op == OP_BEQ) || (op == OP_BNE);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IF;
         op_q    <= 6'b000000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      IRWre     = 1'b0;
      PCWre     = 1'b0;
      PCSrc     = 2'b00;
      mRD       = 1'b0;
      mWR       = 1'b0;
      RegWre    = 1'b0;
      DBDataSrc = 1'b0;
      Halted    = 1'b0;
      RegDst    = is_rtype;
      ALUSrcB   = is_imm || is_mem;
      ExtSel    = !((op == OP_ANDI) || (op == OP_ORI));
      case (op)
         OP_SUB, OP_BEQ, OP_BNE: ALUOp = 3'b001;
         OP_SLT:                 ALUOp = 3'b010;
         OP_OR, OP_ORI:          ALUOp = 3'b011;
         OP_AND, OP_ANDI:        ALUOp = 3'b100;
         default:                ALUOp = 3'b000;
      endcase

      case (state_q)
         S_IF: begin
            IRWre   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            if (op == HALT_OPCODE) begin
               state_d = S_HALT;
            end else if (is_rtype || is_imm) begin
               state_d = S_EXE_AL;
            end else if (is_mem) begin
               state_d = S_EXE_LS;
            end else if (is_br) begin
               state_d = S_EXE_BR;
            end else begin
               // j and unknown opcodes retire straight out of decode
               state_d = S_IF;
               PCWre   = 1'b1;
               if (op == OP_J) PCSrc = 2'b10;
            end
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL: begin
            RegWre  = 1'b1;
            PCWre   = 1'b1;
            state_d = S_IF;
         end
         S_EXE_LS: state_d = S_MEM;
         S_MEM: begin
            if (op == OP_LW) begin
               mRD     = 1'b1;
               state_d = S_WB_LD;
            end else begin
               mWR     = 1'b1;
               PCWre   = 1'b1;
               state_d = S_IF;
            end
         end
         S_WB_LD: begin
            RegWre    = 1'b1;
            DBDataSrc = 1'b1;
            PCWre     = 1'b1;
            state_d   = S_IF;
         end
         S_EXE_BR: begin
            PCWre   = 1'b1;
            state_d = S_IF;
            if (((op == OP_BEQ) && Zero) || ((op == OP_BNE) && !Zero)) PCSrc = 2'b01;
         end
         S_HALT:  Halted  = 1'b1;
         default: state_d = S_IF;
      endcase
   end

   assign State = state_q[2:0];

`ifdef CU_INSTR_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of PCWre pulses.
   always_comb begin
      cnt_d = cnt_q;
      if (PCWre && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign InstrCount = cnt_q;
`else
   assign InstrCount = '0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit against a per-instruction path model.
module tb_multicycle_control_unit;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [5:0]       Opcode;
   logic             Zero;
   logic             IRWre, PCWre, ExtSel, ALUSrcB, mRD, mWR, RegDst, RegWre, DBDataSrc, Halted;
   logic [1:0]       PCSrc;
   logic [2:0]       ALUOp, State;
   logic [CNT_W-1:0] InstrCount;

   int total  = 0;
   int passed = 0;
   int exp_cnt = 0;

   multicycle_control_unit #(.HALT_OPCODE(6'b111111), .CNT_W(CNT_W)) dut (
      .CLK(clk), .Reset(rst), .Opcode(Opcode), .Zero(Zero),
      .IRWre(IRWre), .PCWre(PCWre), .PCSrc(PCSrc), .ExtSel(ExtSel), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .RegDst(RegDst), .RegWre(RegWre),
      .DBDataSrc(DBDataSrc), .State(State), .Halted(Halted), .InstrCount(InstrCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // 0 alu, 1 lw, 2 sw, 3 branch, 4 j/nop, 5 halt
   function automatic int kind(input logic [5:0] op);
      case (op)
         6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
         6'b010010, 6'b010011, 6'b100110: return 0;
         6'b110001: return 1;
         6'b110000: return 2;
         6'b110100, 6'b110101: return 3;
         6'b111111: return 5;
         default:   return 4;
      endcase
   endfunction

   // {RegDst, ALUSrcB, ExtSel, ALUOp}
   function automatic logic [5:0] exp_dp(input logic [5:0] op);
      case (op)
         6'b000000: return {1'b1, 1'b0, 1'b1, 3'b000}; // add
         6'b000001: return {1'b1, 1'b0, 1'b1, 3'b001}; // sub
         6'b000010: return {1'b0, 1'b1, 1'b1, 3'b000}; // addiu
         6'b010000: return {1'b0, 1'b1, 1'b0, 3'b100}; // andi
         6'b010001: return {1'b1, 1'b0, 1'b1, 3'b100}; // and
         6'b010010: return {1'b0, 1'b1, 1'b0, 3'b011}; // ori
         6'b010011: return {1'b1, 1'b0, 1'b1, 3'b011}; // or
         6'b100110: return {1'b1, 1'b0, 1'b1, 3'b010}; // slt
         6'b110000, 6'b110001: return {1'b0, 1'b1, 1'b1, 3'b000};
         6'b110100, 6'b110101: return {1'b0, 1'b0, 1'b1, 3'b001};
         default:   return {1'b0, 1'b0, 1'b1, 3'b000};
      endcase
   endfunction

   function automatic logic [31:0] cnt_expect();
`ifdef CU_INSTR_COUNT_EN
      return exp_cnt;
`else
      return 32'd0;
`endif
   endfunction

   // Entered one tick after a rising edge with the DUT in IF.
   task automatic run_instr(input logic [5:0] op);
      int        k;
      logic [2:0] path[$];
      logic       last, taken, pcwre;
      logic [1:0] pcsrc;
      logic [8:0] ctl_exp;
      k = kind(op);
      case (k)
         0:       path = '{3'd0, 3'd1, 3'd6, 3'd7};
         1:       path = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
         2:       path = '{3'd0, 3'd1, 3'd2, 3'd3};
         3:       path = '{3'd0, 3'd1, 3'd5};
         default: path = '{3'd0, 3'd1};
      endcase
      for (int i = 0; i < path.size(); i++) begin
         Opcode = (i <= 1) ? op : 6'($urandom);
         Zero   = 1'($urandom);
         #1;
         last  = (i == path.size() - 1);
         taken = ((op == 6'b110100) && Zero) || ((op == 6'b110101) && !Zero);
         pcwre = last && (k != 5);
         pcsrc = (i == 1 && op == 6'b111000) ? 2'b10 : ((k == 3 && last && taken) ? 2'b01 : 2'b00);
         ctl_exp = {(i == 0), pcwre, pcsrc, last && (k <= 1), (k == 1 && i == 3),
                    (k == 2 && i == 3), (k == 1 && last), 1'b0};
         chk($sformatf("state op=%b step=%0d", op, i), 32'(State), 32'(path[i]));
         chk($sformatf("ctl op=%b step=%0d", op, i),
             32'({IRWre, PCWre, PCSrc, RegWre, mRD, mWR, DBDataSrc, Halted}), 32'(ctl_exp));
         if (i >= 1)
            chk($sformatf("dp op=%b step=%0d", op, i),
                32'({RegDst, ALUSrcB, ExtSel, ALUOp}), 32'(exp_dp(op)));
         @(posedge clk); #1;
         if (pcwre) exp_cnt++;
      end
      chk($sformatf("count after op=%b", op), InstrCount, cnt_expect());
      $display("instr op=%b kind=%0d cycles=%0d count=%0d", op, k, path.size(), InstrCount);
      if (k == 5) begin
         for (int c = 0; c < 20; c++) begin
            Opcode = 6'($urandom);
            Zero   = 1'($urandom);
            #1;
            chk($sformatf("halt cycle=%0d", c),
                32'({IRWre, PCWre, RegWre, mRD, mWR, Halted}), 32'(6'b000001));
            @(posedge clk); #1;
         end
      end
   endtask

   // Asserts reset asynchronously, checks immediately, releases one tick after the next edge.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      exp_cnt = 0;
      chk("reset state", 32'(State), 32'd0);
      chk("reset ctl", 32'({IRWre, PCWre, PCSrc, RegWre, mRD, mWR, DBDataSrc, Halted}),
          32'(9'b1_0_00_0_0_0_0_0));
      chk("reset count", InstrCount, 32'd0);
      $display("reset applied state=%0d count=%0d", State, InstrCount);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [5:0] ops[13];
      logic [5:0] op;
      ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b010011,
              6'b100110, 6'b110000, 6'b110001, 6'b110100, 6'b110101, 6'b111000};
      rst = 1'b1; Opcode = 6'b0; Zero = 1'b0;
      #1;
      do_reset();

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom);
            if (op == 6'b111111) op = 6'b101010;
         end else begin
            op = ops[$urandom_range(0, 12)];
         end
         run_instr(op);
      end

      do_reset();
      run_instr(6'b000000);
      run_instr(6'b110000);
      run_instr(6'b111000);
      run_instr(6'b101010);
`ifdef CU_INSTR_COUNT_EN
      chk("count four retired", InstrCount, 32'd4);
`else
      chk("count tied zero", InstrCount, 32'd0);
`endif

      // Reset arriving mid-add while in EXE_AL
      Opcode = 6'b000000; Zero = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid add in EXE_AL", 32'(State), 32'd6);
      do_reset();

      run_instr(6'b111000);
      run_instr(6'b111111);
      do_reset();
      run_instr(6'b110001);
      run_instr(6'b110101);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
